// File: rtl/issue_queue_age_if.sv
// Dispatch and issue handshake bundle for issue_queue_age.
// master = dispatch/FU side, slave = the issue queue.
interface issue_queue_age_if #(
   parameter int PREG_W    = 7,
   parameter int ROB_W     = 5,
   parameter int PAYLOAD_W = 64
) ();
   logic                 disp_valid;
   logic                 disp_ready;
   logic [PREG_W-1:0]    disp_ps1;
   logic [PREG_W-1:0]    disp_ps2;
   logic [PREG_W-1:0]    disp_pd;
   logic [ROB_W-1:0]     disp_rob;
   logic [PAYLOAD_W-1:0] disp_payload;

   logic                 iss_valid;
   logic                 iss_ready;
   logic [PREG_W-1:0]    iss_ps1;
   logic [PREG_W-1:0]    iss_ps2;
   logic [PREG_W-1:0]    iss_pd;
   logic [ROB_W-1:0]     iss_rob;
   logic [PAYLOAD_W-1:0] iss_payload;

   modport master (
      output disp_valid, disp_ps1, disp_ps2, disp_pd, disp_rob, disp_payload,
      input  disp_ready,
      input  iss_valid, iss_ps1, iss_ps2, iss_pd, iss_rob, iss_payload,
      output iss_ready
   );

   modport slave (
      input  disp_valid, disp_ps1, disp_ps2, disp_pd, disp_rob, disp_payload,
      output disp_ready,
      output iss_valid, iss_ps1, iss_ps2, iss_pd, iss_rob, iss_payload,
      input  iss_ready
   );
endinterface

// File: rtl/issue_queue_age.sv
// Age-ordered reservation station with tag-broadcast wakeup and wrap-aware partial flush.
// Optional macro RS_BYPASS_EN: wakeups coinciding with dispatch set the new entry's ready bits.
module issue_queue_age #(
   parameter int DEPTH     = 8,
   parameter int PREG_W    = 7,
   parameter int ROB_W     = 5,
   parameter int NUM_WK    = 2,
   parameter int PAYLOAD_W = 64
) (
   input  logic                          clk,
   input  logic                          reset,
   issue_queue_age_if.slave              bus,
   input  logic [(1<<PREG_W)-1:0]        preg_ready_i,
   input  logic [NUM_WK-1:0]             wk_valid_i,
   input  logic [NUM_WK*PREG_W-1:0]      wk_preg_i,
   input  logic [ROB_W-1:0]              rob_head_i,
   input  logic                          flush_i,
   input  logic [ROB_W-1:0]              flush_rob_i,
   output logic [$clog2(DEPTH+1)-1:0]    count_o
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   function automatic logic [ROB_W-1:0] age_of(input logic [ROB_W-1:0] rob,
                                                input logic [ROB_W-1:0] head);
      age_of = rob - head;
   endfunction

   logic [DEPTH-1:0]     valid_q, rdy1_q, rdy2_q;
   logic [PREG_W-1:0]    ps1_q [DEPTH];
   logic [PREG_W-1:0]    ps2_q [DEPTH];
   logic [PREG_W-1:0]    pd_q  [DEPTH];
   logic [ROB_W-1:0]     rob_q [DEPTH];
   logic [PAYLOAD_W-1:0] payload_q [DEPTH];

   logic                 iss_valid_q;
   logic [PREG_W-1:0]    iss_ps1_q, iss_ps2_q, iss_pd_q;
   logic [ROB_W-1:0]     iss_rob_q;
   logic [PAYLOAD_W-1:0] iss_payload_q;

   logic [DEPTH-1:0][NUM_WK-1:0] wk_hit1, wk_hit2;
   logic [DEPTH-1:0]     kill;
   logic [ROB_W-1:0]     flush_age;
   logic                 free_found, sel_found;
   logic [IDX_W-1:0]     free_idx, sel_idx;
   logic [ROB_W-1:0]     sel_age;
   logic [CNT_W-1:0]     cnt;
   logic                 disp_fire, iss_fire, iss_kill;
   logic                 disp_rdy1, disp_rdy2;

   assign flush_age = age_of(flush_rob_i, rob_head_i);

   genvar gi, gk;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         for (gk = 0; gk < NUM_WK; gk++) begin : g_port
            assign wk_hit1[gi][gk] = wk_valid_i[gk] && (wk_preg_i[gk*PREG_W +: PREG_W] == ps1_q[gi]);
            assign wk_hit2[gi][gk] = wk_valid_i[gk] && (wk_preg_i[gk*PREG_W +: PREG_W] == ps2_q[gi]);
         end
         // Strictly younger than the mispredicting µop; equal age survives.
         assign kill[gi] = flush_i && (age_of(rob_q[gi], rob_head_i) > flush_age);
      end
   endgenerate

`ifdef RS_BYPASS_EN
   logic [NUM_WK-1:0] disp_m1, disp_m2;
   generate
      for (gk = 0; gk < NUM_WK; gk++) begin : g_bypass
         assign disp_m1[gk] = wk_valid_i[gk] && (wk_preg_i[gk*PREG_W +: PREG_W] == bus.disp_ps1);
         assign disp_m2[gk] = wk_valid_i[gk] && (wk_preg_i[gk*PREG_W +: PREG_W] == bus.disp_ps2);
      end
   endgenerate
   assign disp_rdy1 = preg_ready_i[bus.disp_ps1] | (|disp_m1);
   assign disp_rdy2 = preg_ready_i[bus.disp_ps2] | (|disp_m2);
`else
   assign disp_rdy1 = preg_ready_i[bus.disp_ps1];
   assign disp_rdy2 = preg_ready_i[bus.disp_ps2];
`endif

   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      cnt        = '0;
      for (int i = 0; i < DEPTH; i++) begin
         cnt = cnt + CNT_W'(valid_q[i]);
         if (!valid_q[i] && !free_found) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   // Strict less-than keeps the lower index on equal ages.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      sel_age   = '1;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && rdy1_q[i] && rdy2_q[i] &&
             (!sel_found || age_of(rob_q[i], rob_head_i) < sel_age)) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
            sel_age   = age_of(rob_q[i], rob_head_i);
         end
      end
   end

   assign disp_fire = bus.disp_valid && free_found && !flush_i;
   assign iss_fire  = sel_found && !flush_i && (!iss_valid_q || bus.iss_ready);
   assign iss_kill  = flush_i && (age_of(iss_rob_q, rob_head_i) > flush_age);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         rdy1_q  <= '0;
         rdy2_q  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (disp_fire && free_idx == IDX_W'(i)) begin
               valid_q[i] <= 1'b1;
               rdy1_q[i]  <= disp_rdy1;
               rdy2_q[i]  <= disp_rdy2;
            end else if (kill[i] || (iss_fire && sel_idx == IDX_W'(i))) begin
               valid_q[i] <= 1'b0;
               rdy1_q[i]  <= 1'b0;
               rdy2_q[i]  <= 1'b0;
            end else if (valid_q[i]) begin
               rdy1_q[i]  <= rdy1_q[i] | (|wk_hit1[i]);
               rdy2_q[i]  <= rdy2_q[i] | (|wk_hit2[i]);
            end
         end
      end
   end

   // Entry payload storage carries no reset; valid_q qualifies it.
   always_ff @(posedge clk) begin
      if (disp_fire) begin
         ps1_q[free_idx]     <= bus.disp_ps1;
         ps2_q[free_idx]     <= bus.disp_ps2;
         pd_q[free_idx]      <= bus.disp_pd;
         rob_q[free_idx]     <= bus.disp_rob;
         payload_q[free_idx] <= bus.disp_payload;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         iss_valid_q   <= 1'b0;
         iss_ps1_q     <= '0;
         iss_ps2_q     <= '0;
         iss_pd_q      <= '0;
         iss_rob_q     <= '0;
         iss_payload_q <= '0;
      end else if (iss_fire) begin
         iss_valid_q   <= 1'b1;
         iss_ps1_q     <= ps1_q[sel_idx];
         iss_ps2_q     <= ps2_q[sel_idx];
         iss_pd_q      <= pd_q[sel_idx];
         iss_rob_q     <= rob_q[sel_idx];
         iss_payload_q <= payload_q[sel_idx];
      end else if (iss_valid_q && (bus.iss_ready || iss_kill)) begin
         iss_valid_q   <= 1'b0;
      end
   end

   assign bus.disp_ready  = free_found;
   assign count_o         = cnt;
   assign bus.iss_valid   = iss_valid_q;
   assign bus.iss_ps1     = iss_ps1_q;
   assign bus.iss_ps2     = iss_ps2_q;
   assign bus.iss_pd      = iss_pd_q;
   assign bus.iss_rob     = iss_rob_q;
   assign bus.iss_payload = iss_payload_q;
endmodule

// File: tb/tb_issue_queue_age.sv
// Directed self-checking bench for issue_queue_age (DEPTH=8, two wakeup ports).
// Honours RS_BYPASS_EN in the same way as the design.
module tb_issue_queue_age;
   localparam int DEPTH = 8, PREG_W = 7, ROB_W = 5, NUM_WK = 2, PAYLOAD_W = 64;

   logic                       clk = 1'b0;
   logic                       reset;
   logic [(1<<PREG_W)-1:0]     preg_ready;
   logic [NUM_WK-1:0]          wk_valid;
   logic [NUM_WK*PREG_W-1:0]   wk_preg;
   logic [ROB_W-1:0]           rob_head;
   logic                       flush;
   logic [ROB_W-1:0]           flush_rob;
   logic [$clog2(DEPTH+1)-1:0] count;
   int checks = 0;
   int errors = 0;

   issue_queue_age_if #(.PREG_W(PREG_W), .ROB_W(ROB_W), .PAYLOAD_W(PAYLOAD_W)) bus ();

   issue_queue_age #(.DEPTH(DEPTH), .PREG_W(PREG_W), .ROB_W(ROB_W),
                     .NUM_WK(NUM_WK), .PAYLOAD_W(PAYLOAD_W)) dut (
      .clk(clk), .reset(reset), .bus(bus), .preg_ready_i(preg_ready),
      .wk_valid_i(wk_valid), .wk_preg_i(wk_preg), .rob_head_i(rob_head),
      .flush_i(flush), .flush_rob_i(flush_rob), .count_o(count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.disp_valid = 0; bus.disp_ps1 = '0; bus.disp_ps2 = '0; bus.disp_pd = '0;
      bus.disp_rob = '0; bus.disp_payload = '0; bus.iss_ready = 0;
      preg_ready = '0; wk_valid = '0; wk_preg = '0; rob_head = '0; flush = 0; flush_rob = '0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      reset = 1; tick(); tick();
      reset = 0; tick();
   endtask

   task automatic disp(input logic [ROB_W-1:0] rob, input logic [PREG_W-1:0] ps1,
                       input logic [PREG_W-1:0] ps2, input logic [PAYLOAD_W-1:0] pl);
      bus.disp_valid = 1; bus.disp_rob = rob; bus.disp_ps1 = ps1; bus.disp_ps2 = ps2;
      bus.disp_pd = ps1 ^ ps2; bus.disp_payload = pl;
      tick();
      bus.disp_valid = 0;
      $display("dispatch rob=%0d ps1=%0d ps2=%0d count=%0d", rob, ps1, ps2, count);
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1;
      #2;
      checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL reset_iss_valid got=%b exp=0", bus.iss_valid); end
      checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (bus.disp_ready !== 1'b1) begin errors++; $display("FAIL reset_disp_ready got=%b exp=1", bus.disp_ready); end
      checks++; if (bus.iss_rob !== 5'd0 || bus.iss_payload !== 64'd0 || bus.iss_pd !== 7'd0)
         begin errors++; $display("FAIL reset_iss_fields got rob=%0d pl=%h exp 0", bus.iss_rob, bus.iss_payload); end
      tick(); reset = 0; tick();
   endtask

   task automatic test_fill();
      apply_reset();
      bus.iss_ready = 1;
      for (int i = 0; i < DEPTH; i++) disp(5'(i), 7'd5, 7'd6, 64'(100 + i));
      checks++; if (count !== 4'd8) begin errors++; $display("FAIL fill_count got=%0d exp=8", count); end
      checks++; if (bus.disp_ready !== 1'b0) begin errors++; $display("FAIL fill_disp_ready got=%b exp=0", bus.disp_ready); end
      checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL fill_iss_valid got=%b exp=0", bus.iss_valid); end
      disp(5'd8, 7'd5, 7'd6, 64'd108);
      checks++; if (count !== 4'd8) begin errors++; $display("FAIL ninth_ignored count got=%0d exp=8", count); end
      #2 reset = 1;
      #1;
      checks++; if (count !== 4'd0 || bus.disp_ready !== 1'b1)
         begin errors++; $display("FAIL async_reset count got=%0d rdy=%b exp 0/1", count, bus.disp_ready); end
      tick(); reset = 0; tick();
   endtask

   task automatic test_wrap_order();
      logic [ROB_W-1:0] exp_rob [3];
      exp_rob[0] = 5'd30; exp_rob[1] = 5'd31; exp_rob[2] = 5'd1;
      apply_reset();
      rob_head = 5'd30; bus.iss_ready = 1;
      disp(5'd1, 7'd5, 7'd5, 64'hA1);
      disp(5'd31, 7'd5, 7'd5, 64'hA31);
      disp(5'd30, 7'd5, 7'd5, 64'hA30);
      checks++; if (count !== 4'd3) begin errors++; $display("FAIL wrap_count got=%0d exp=3", count); end
      wk_valid = 2'b01; wk_preg[0 +: PREG_W] = 7'd5;
      tick();
      wk_valid = '0;
      checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL wrap_early got=%b exp=0", bus.iss_valid); end
      for (int i = 0; i < 3; i++) begin
         tick();
         $display("issue rob=%0d valid=%b", bus.iss_rob, bus.iss_valid);
         checks++; if (bus.iss_valid !== 1'b1 || bus.iss_rob !== exp_rob[i])
            begin errors++; $display("FAIL wrap_order%0d got v=%b rob=%0d exp rob=%0d", i, bus.iss_valid, bus.iss_rob, exp_rob[i]); end
      end
      checks++; if (bus.iss_payload !== 64'hA1) begin errors++; $display("FAIL wrap_payload got=%h exp=a1", bus.iss_payload); end
      tick();
      checks++; if (bus.iss_valid !== 1'b0 || count !== 4'd0)
         begin errors++; $display("FAIL wrap_drain got v=%b count=%0d exp 0/0", bus.iss_valid, count); end
   endtask

   task automatic test_wakeup();
      apply_reset();
      preg_ready[1] = 1; bus.iss_ready = 1;
      disp(5'd3, 7'd40, 7'd1, 64'hCAFE);
      tick();
      checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL wk_wait got=%b exp=0", bus.iss_valid); end
      wk_valid = 2'b10; wk_preg[0 +: PREG_W] = 7'd9; wk_preg[PREG_W +: PREG_W] = 7'd40;
      tick();
      wk_valid = '0;
      checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL wk_edgeN got=%b exp=0", bus.iss_valid); end
      tick();
      $display("issue rob=%0d valid=%b", bus.iss_rob, bus.iss_valid);
      checks++; if (bus.iss_valid !== 1'b1 || bus.iss_rob !== 5'd3 || bus.iss_ps1 !== 7'd40 ||
                    bus.iss_ps2 !== 7'd1 || bus.iss_pd !== 7'd41 || bus.iss_payload !== 64'hCAFE)
         begin errors++; $display("FAIL wk_issue got v=%b rob=%0d ps1=%0d pd=%0d pl=%h exp 1/3/40/41/cafe",
                                  bus.iss_valid, bus.iss_rob, bus.iss_ps1, bus.iss_pd, bus.iss_payload); end
   endtask

   task automatic test_flush();
      apply_reset();
      rob_head = 5'd28;
      disp(5'd29, 7'd5, 7'd5, 64'h29);
      disp(5'd31, 7'd5, 7'd5, 64'h31);
      disp(5'd2, 7'd5, 7'd5, 64'h02);
      disp(5'd5, 7'd5, 7'd5, 64'h05);
      flush = 1; flush_rob = 5'd31;
      bus.disp_valid = 1; bus.disp_rob = 5'd30; bus.disp_ps1 = 7'd5; bus.disp_ps2 = 7'd5;
      tick();
      flush = 0; bus.disp_valid = 0;
      checks++; if (count !== 4'd2) begin errors++; $display("FAIL flush_count got=%0d exp=2", count); end
      bus.iss_ready = 1; wk_valid = 2'b01; wk_preg[0 +: PREG_W] = 7'd5;
      tick();
      wk_valid = '0;
      tick();
      checks++; if (bus.iss_valid !== 1'b1 || bus.iss_rob !== 5'd29)
         begin errors++; $display("FAIL flush_surv0 got v=%b rob=%0d exp rob=29", bus.iss_valid, bus.iss_rob); end
      tick();
      checks++; if (bus.iss_valid !== 1'b1 || bus.iss_rob !== 5'd31)
         begin errors++; $display("FAIL flush_surv1 got v=%b rob=%0d exp rob=31", bus.iss_valid, bus.iss_rob); end
      tick();
      checks++; if (bus.iss_valid !== 1'b0 || count !== 4'd0)
         begin errors++; $display("FAIL flush_drain got v=%b count=%0d exp 0/0", bus.iss_valid, count); end
   endtask

   task automatic test_flush_iss();
      apply_reset();
      preg_ready[1] = 1;
      disp(5'd4, 7'd1, 7'd1, 64'h44);
      tick();
      flush = 1; flush_rob = 5'd4;
      tick();
      checks++; if (bus.iss_valid !== 1'b1 || bus.iss_rob !== 5'd4)
         begin errors++; $display("FAIL flush_iss_keep got v=%b rob=%0d exp 1/4", bus.iss_valid, bus.iss_rob); end
      flush_rob = 5'd2;
      tick();
      flush = 0;
      checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL flush_iss_kill got=%b exp=0", bus.iss_valid); end
   endtask

   task automatic test_back_to_back_stall();
      apply_reset();
      rob_head = 5'd10; preg_ready[1] = 1;
      disp(5'd10, 7'd1, 7'd1, 64'h10);
      disp(5'd11, 7'd1, 7'd1, 64'h11);
      checks++; if (bus.iss_valid !== 1'b1 || bus.iss_rob !== 5'd10 || count !== 4'd1)
         begin errors++; $display("FAIL stall_first got v=%b rob=%0d count=%0d exp 1/10/1", bus.iss_valid, bus.iss_rob, count); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (bus.iss_valid !== 1'b1 || bus.iss_rob !== 5'd10 || bus.iss_payload !== 64'h10 || count !== 4'd1)
            begin errors++; $display("FAIL stall_hold%0d got v=%b rob=%0d count=%0d exp 1/10/1", i, bus.iss_valid, bus.iss_rob, count); end
      end
      bus.iss_ready = 1;
      tick();
      $display("issue rob=%0d valid=%b", bus.iss_rob, bus.iss_valid);
      checks++; if (bus.iss_valid !== 1'b1 || bus.iss_rob !== 5'd11 || bus.iss_payload !== 64'h11)
         begin errors++; $display("FAIL stall_next got v=%b rob=%0d exp 1/11", bus.iss_valid, bus.iss_rob); end
      tick();
      checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got=%b exp=0", bus.iss_valid); end
   endtask

   task automatic test_bypass();
      apply_reset();
      preg_ready[1] = 1; bus.iss_ready = 1;
      wk_valid = 2'b01; wk_preg[0 +: PREG_W] = 7'd12;
      disp(5'd7, 7'd12, 7'd1, 64'h77);
      wk_valid = '0;
      checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL byp_early got=%b exp=0", bus.iss_valid); end
      tick();
`ifdef RS_BYPASS_EN
      checks++; if (bus.iss_valid !== 1'b1 || bus.iss_rob !== 5'd7)
         begin errors++; $display("FAIL byp_issue got v=%b rob=%0d exp 1/7", bus.iss_valid, bus.iss_rob); end
`else
      for (int i = 0; i < 3; i++) begin
         checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL nobyp_wait%0d got=%b exp=0", i, bus.iss_valid); end
         tick();
      end
      wk_valid = 2'b01; wk_preg[0 +: PREG_W] = 7'd12;
      tick();
      wk_valid = '0;
      tick();
      checks++; if (bus.iss_valid !== 1'b1 || bus.iss_rob !== 5'd7)
         begin errors++; $display("FAIL nobyp_late got v=%b rob=%0d exp 1/7", bus.iss_valid, bus.iss_rob); end
`endif
   endtask

   initial begin
      test_reset();
      test_fill();
      test_wrap_order();
      test_wakeup();
      test_flush();
      test_flush_iss();
      test_back_to_back_stall();
      test_bypass();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
